// File: rtl/vid_sync_lock_ctrl.sv
// Video sync lock controller: measures the line period and lines per frame of
// the incoming hsync/vsync pair, runs a search/acquire/locked/hold state
// machine, and reports lock status, frame-start and loss-of-lock strobes plus
// a saturating count of bad frames seen while locked.
module vid_sync_lock_ctrl #(
  parameter int H_ACTIVE      = -1,
  parameter int H_FRONT_PORCH = -1,
  parameter int H_SYNC_WIDTH  = -1,
  parameter int H_BACK_PORCH  = -1,
  parameter int V_ACTIVE      = -1,
  parameter int V_FRONT_PORCH = -1,
  parameter int V_SYNC_WIDTH  = -1,
  parameter int V_BACK_PORCH  = -1,
  parameter int H_FRAME       = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
  parameter int V_FRAME       = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
  parameter int LOCK_FRAMES   = 3,
  parameter int UNLOCK_ERRS   = 2,
  parameter int WDOG          = 2 * H_FRAME * V_FRAME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vsync,
  input  logic        in_hsync,
  output logic [1:0]  out_state,
  output logic        out_locked,
  output logic        out_frame_start,
  output logic        out_lock_lost,
  output logic [15:0] out_err_frames
);

  // Clamp the timing so counter widths stay legal even with the unset defaults.
  localparam int H_FRAME_C = (H_FRAME > 1) ? H_FRAME : 2;
  localparam int V_FRAME_C = (V_FRAME > 1) ? V_FRAME : 2;
  localparam int WDOG_C    = (WDOG > 1) ? WDOG : 2;
  localparam int LOCK_C    = (LOCK_FRAMES > 0) ? LOCK_FRAMES : 1;
  localparam int UNLOCK_C  = (UNLOCK_ERRS > 0) ? UNLOCK_ERRS : 1;

  localparam int HW = $clog2(H_FRAME_C) + 1;
  localparam int VW = $clog2(V_FRAME_C) + 1;
  localparam int WW = $clog2(WDOG_C) + 1;
  localparam int GW = $clog2(LOCK_C) + 1;
  localparam int EW = $clog2(UNLOCK_C) + 1;

  localparam logic [HW-1:0] H_FRAME_V = HW'(H_FRAME_C);
  localparam logic [VW-1:0] V_FRAME_V = VW'(V_FRAME_C);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_C - 1);
  localparam logic [GW-1:0] LOCK_V    = GW'(LOCK_C);
  localparam logic [EW-1:0] UNLOCK_V  = EW'(UNLOCK_C);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t        state_q;
  logic          prev_h_q, prev_v_q;
  logic [HW-1:0] hper_q;
  logic [VW-1:0] lines_q;
  logic [WW-1:0] wdog_q;
  logic [GW-1:0] good_cnt_q;
  logic [EW-1:0] err_cnt_q;
  logic          hseen_q, vseen_q, line_err_q;

  logic          hs_rise, vs_rise, line_bad, frame_good, wd_fire, in_lock;
  logic [HW-1:0] hper_d;
  logic [VW-1:0] lines_d;
  logic [WW-1:0] wdog_d;
  logic [GW-1:0] good_inc;
  logic [EW-1:0] err_inc;
  logic [15:0]   err_frames_d;

  assign hs_rise  = in_hsync & ~prev_h_q;
  assign vs_rise  = in_vsync & ~prev_v_q;
  // A line is judged only once a previous rise has opened it.
  assign line_bad = hs_rise & hseen_q & (hper_q != H_FRAME_V);
  // The frame is judged on the pre-update line count and sticky error.
  assign frame_good = vseen_q & (lines_q == V_FRAME_V) & ~line_err_q;
  assign wd_fire  = ~vs_rise & (wdog_q == WDOG_LAST);
  assign in_lock  = (state_q == ST_LOCKED) | (state_q == ST_HOLD);

  // Saturating increments shared by the counters.
  assign hper_d       = (&hper_q) ? hper_q : hper_q + 1'b1;
  assign lines_d      = (&lines_q) ? lines_q : lines_q + 1'b1;
  assign wdog_d       = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
  assign good_inc     = good_cnt_q + 1'b1;
  assign err_inc      = err_cnt_q + 1'b1;
  assign err_frames_d = (&out_err_frames) ? out_err_frames : out_err_frames + 16'd1;

  assign out_state = state_q;

  // Measurement counters, watchdog and lock state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_SEARCH;
      prev_h_q        <= 1'b0;
      prev_v_q        <= 1'b0;
      hper_q          <= '0;
      lines_q         <= '0;
      wdog_q          <= '0;
      good_cnt_q      <= '0;
      err_cnt_q       <= '0;
      hseen_q         <= 1'b0;
      vseen_q         <= 1'b0;
      line_err_q      <= 1'b0;
      out_locked      <= 1'b0;
      out_frame_start <= 1'b0;
      out_lock_lost   <= 1'b0;
      out_err_frames  <= '0;
    end else begin
      prev_h_q        <= in_hsync;
      prev_v_q        <= in_vsync;
      out_frame_start <= 1'b0;
      out_lock_lost   <= 1'b0;

      // Close the current line on an hsync rise and open the next one.
      if (hs_rise) begin
        hper_q  <= {{(HW-1){1'b0}}, 1'b1};
        hseen_q <= 1'b1;
        lines_q <= lines_d;
        if (line_bad) line_err_q <= 1'b1;
      end else begin
        hper_q <= hper_d;
      end

      if (vs_rise) begin
        // A coincident hsync rise becomes line 1 of the new frame.
        vseen_q    <= 1'b1;
        wdog_q     <= '0;
        lines_q    <= hs_rise ? {{(VW-1){1'b0}}, 1'b1} : '0;
        line_err_q <= line_bad;
        case (state_q)
          ST_SEARCH: begin
            state_q    <= ST_ACQUIRE;
            good_cnt_q <= '0;
          end
          ST_ACQUIRE: begin
            if (frame_good) begin
              if (good_inc == LOCK_V) begin
                state_q         <= ST_LOCKED;
                out_locked      <= 1'b1;
                out_frame_start <= 1'b1;
              end else begin
                good_cnt_q <= good_inc;
              end
            end else begin
              good_cnt_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (frame_good) begin
              out_frame_start <= 1'b1;
            end else begin
              out_err_frames <= err_frames_d;
              err_cnt_q      <= {{(EW-1){1'b0}}, 1'b1};
              if (UNLOCK_C == 1) begin
                state_q       <= ST_SEARCH;
                out_locked    <= 1'b0;
                out_lock_lost <= 1'b1;
              end else begin
                state_q         <= ST_HOLD;
                out_frame_start <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (frame_good) begin
              state_q         <= ST_LOCKED;
              err_cnt_q       <= '0;
              out_frame_start <= 1'b1;
            end else begin
              out_err_frames <= err_frames_d;
              if (err_inc == UNLOCK_V) begin
                state_q       <= ST_SEARCH;
                out_locked    <= 1'b0;
                out_lock_lost <= 1'b1;
              end else begin
                err_cnt_q       <= err_inc;
                out_frame_start <= 1'b1;
              end
            end
          end
          default: state_q <= ST_SEARCH;
        endcase
      end else begin
        wdog_q <= wdog_d;
        // No vsync for too long: drop to search and forget what was seen.
        if (wd_fire) begin
          state_q       <= ST_SEARCH;
          vseen_q       <= 1'b0;
          hseen_q       <= 1'b0;
          out_locked    <= 1'b0;
          out_lock_lost <= in_lock;
        end
      end
    end
  end

endmodule

// File: tb/tb_vid_sync_lock_ctrl.sv
// Bench for vid_sync_lock_ctrl: directed scenarios with literal expectations
// followed by a randomized sync stream, all checked every cycle against a
// timestamp-based behavioural model.
module tb_vid_sync_lock_ctrl;

  localparam int HF   = 16;
  localparam int VF   = 8;
  localparam int LOCK = 3;
  localparam int UNL  = 2;
  localparam int WD   = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vsync, in_hsync;
  logic [1:0]  out_state;
  logic        out_locked, out_frame_start, out_lock_lost;
  logic [15:0] out_err_frames;

  int n_tests = 0;
  int n_fail  = 0;

  vid_sync_lock_ctrl #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2), .H_BACK_PORCH(4),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(2),
    .LOCK_FRAMES(LOCK), .UNLOCK_ERRS(UNL), .WDOG(WD)
  ) dut (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .out_state(out_state), .out_locked(out_locked),
    .out_frame_start(out_frame_start), .out_lock_lost(out_lock_lost),
    .out_err_frames(out_err_frames)
  );

  always #5 clk = ~clk;

  // Behavioural model: timestamps of the last hsync/vsync rise, a plain line
  // count and a sticky error flag, plus the lock rules as written.
  int m_cyc = 0;
  int m_last_h = 0;
  int m_last_v = 0;
  bit m_hseen, m_vseen, m_lerr, m_ph, m_pv;
  int m_lines, m_state, m_good, m_errc, m_errf, m_old;
  bit m_fs, m_ll, m_hr, m_vr, m_lbad, m_okf, m_fire;

  always @(posedge clk) begin
    m_cyc = m_cyc + 1;
    if (rst) begin
      m_hseen = 0; m_vseen = 0; m_lerr = 0; m_ph = 0; m_pv = 0;
      m_lines = 0; m_state = 0; m_good = 0; m_errc = 0; m_errf = 0;
      m_fs = 0; m_ll = 0; m_last_v = m_cyc;
    end else begin
      m_hr = in_hsync && !m_ph;
      m_vr = in_vsync && !m_pv;
      m_ph = in_hsync;
      m_pv = in_vsync;
      m_lbad = m_hr && m_hseen && ((m_cyc - m_last_h) != HF);
      m_okf  = m_vseen && (m_lines == VF) && !m_lerr;
      m_fire = !m_vr && ((m_cyc - m_last_v) == WD);
      m_old = m_state;
      m_fs = 0;
      m_ll = 0;
      if (m_vr) begin
        case (m_state)
          0: begin m_state = 1; m_good = 0; end
          1: if (m_okf) begin
               if (m_good + 1 == LOCK) m_state = 2; else m_good = m_good + 1;
             end else m_good = 0;
          2: if (!m_okf) begin m_errc = 1; m_state = (UNL == 1) ? 0 : 3; end
          default: if (m_okf) begin m_state = 2; m_errc = 0; end
                   else if (m_errc + 1 == UNL) m_state = 0;
                   else m_errc = m_errc + 1;
        endcase
        if (m_old >= 2 && !m_okf && m_errf < 65535) m_errf = m_errf + 1;
        m_fs = (m_state >= 2);
        m_ll = (m_old >= 2) && (m_state == 0);
        m_vseen = 1;
        m_last_v = m_cyc;
        m_lines = m_hr ? 1 : 0;
        m_lerr = m_lbad;
      end else begin
        if (m_hr) begin
          m_lines = m_lines + 1;
          m_lerr = m_lerr | m_lbad;
        end
        if (m_fire) begin
          m_ll = (m_old >= 2);
          m_state = 0;
          m_vseen = 0;
        end
      end
      if (m_hr) begin m_last_h = m_cyc; m_hseen = 1; end
      if (m_fire) m_hseen = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given sync levels; outputs are compared to the model
  // 1 time unit after the edge.
  task automatic tick(input logic h, input logic v);
    in_hsync = h;
    in_vsync = v;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_state !== 2'(m_state) || out_locked !== (m_state >= 2) ||
        out_frame_start !== m_fs || out_lock_lost !== m_ll ||
        out_err_frames !== 16'(m_errf)) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL model_cycle %0d: got st=%0d lk=%0b fs=%0b ll=%0b ef=%0d expected st=%0d lk=%0b fs=%0b ll=%0b ef=%0d",
                 m_cyc, out_state, out_locked, out_frame_start, out_lock_lost, out_err_frames,
                 m_state, (m_state >= 2), m_fs, m_ll, m_errf);
    end
  endtask

  int cap_state, cap_locked, cap_fs, cap_ll, cap_err;

  // One frame: hsync high for 2 clocks at each line start, vsync high for 4
  // clocks starting voff clocks into line 0. Outputs are captured right after
  // the vsync-rise edge.
  task automatic frame(input int nl, input int long_l, input int extra, input int voff);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = HF + ((l == long_l) ? extra : 0);
      for (int c = 0; c < len; c++) begin
        tick(c < 2, (l == 0) && (c >= voff) && (c < voff + 4));
        if (l == 0 && c == voff) begin
          cap_state = out_state; cap_locked = out_locked; cap_fs = out_frame_start;
          cap_ll = out_lock_lost; cap_err = out_err_frames;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    check("reset_state", out_state, 0);
    check("reset_locked", out_locked, 0);
    check("reset_fs", out_frame_start, 0);
    check("reset_ll", out_lock_lost, 0);
    check("reset_err", out_err_frames, 0);
    rst = 1'b0;
    repeat (2) tick(1'b0, 1'b0);

    // Clean stream: ACQUIRE after first rise, LOCKED after three more.
    frame(8, -1, 0, 0); check("acq_rise1", cap_state, 1);
    frame(8, -1, 0, 0); check("acq_rise2", cap_state, 1);
    frame(8, -1, 0, 0); check("acq_rise3", cap_state, 1);
    frame(8, -1, 0, 0); check("lock_state", cap_state, 2);
    check("lock_locked", cap_locked, 1);
    check("lock_fs", cap_fs, 1);
    frame(8, -1, 0, 0); check("locked_fs_again", cap_fs, 1);

    // One 17-clock line: HOLD then back to LOCKED.
    frame(8, 3, 1, 0); check("pre_long_state", cap_state, 2);
    frame(8, -1, 0, 0); check("hold_state", cap_state, 3);
    check("hold_err", cap_err, 1);
    frame(8, -1, 0, 0); check("relock_state", cap_state, 2);

    // Reset while locked, mid-line.
    for (int i = 0; i < 40; i++) tick((i % 16) < 2, i < 4);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    check("midrst_state", out_state, 0);
    check("midrst_locked", out_locked, 0);
    check("midrst_fs", out_frame_start, 0);
    check("midrst_ll", out_lock_lost, 0);
    check("midrst_err", out_err_frames, 0);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    frame(8, -1, 0, 0); check("rst_acq1", cap_state, 1);
    frame(8, -1, 0, 0); check("rst_acq2", cap_state, 1);
    frame(8, -1, 0, 0); check("rst_acq3", cap_state, 1);
    frame(8, -1, 0, 0); check("rst_relock", cap_state, 2);

    // Two 9-line frames while locked: HOLD, then SEARCH.
    frame(9, -1, 0, 0); check("nine_pre", cap_state, 2);
    frame(9, -1, 0, 0); check("nine_hold", cap_state, 3);
    check("nine_err1", cap_err, 1);
    frame(8, -1, 0, 0); check("nine_search", cap_state, 0);
    check("nine_ll", cap_ll, 1);
    check("nine_locked", cap_locked, 0);
    check("nine_err2", cap_err, 2);
    check("nine_fs", cap_fs, 0);

    // Relock, then stop vsync: watchdog fires 256 clocks after the last rise.
    frame(8, -1, 0, 0); check("wd_acq", cap_state, 1);
    frame(8, -1, 0, 0);
    frame(8, -1, 0, 0);
    for (int i = 0; i < 304; i++) begin
      tick((i % 16) < 2, i < 4);
      if (i == 0)   check("wd_locked", out_state, 2);
      if (i == 255) check("wd_not_yet", out_state, 2);
      if (i == 256) begin
        check("wd_search", out_state, 0);
        check("wd_ll", out_lock_lost, 1);
      end
      if (i == 257) check("wd_ll_single", out_lock_lost, 0);
    end
    frame(8, -1, 0, 0); check("wd_next_acq", cap_state, 1);

    // ACQUIRE with two good frames, one bad frame, then three good to lock.
    frame(8, -1, 0, 0); check("acqbad_g1", cap_state, 1);
    frame(9, -1, 0, 0); check("acqbad_g2", cap_state, 1);
    frame(8, -1, 0, 0); check("acqbad_bad", cap_state, 1);
    frame(8, -1, 0, 0); check("acqbad_r1", cap_state, 1);
    frame(8, -1, 0, 0); check("acqbad_r2", cap_state, 1);
    frame(8, -1, 0, 0); check("acqbad_lock", cap_state, 2);

    // Randomized stream checked cycle by cycle against the model.
    for (int k = 0; k < 48; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) begin
        frame(8, -1, 0, 0);
      end else if (r < 12) begin
        frame(8, -1, 0, $urandom_range(1, 5));
      end else if (r < 15) begin
        frame(($urandom_range(0, 1) == 0) ? 7 : 9, -1, 0, 0);
      end else if (r < 18) begin
        int e;
        e = $urandom_range(1, 3);
        if ($urandom_range(0, 1) == 0) e = -e;
        frame(8, $urandom_range(0, 7), e, 0);
      end else if (r == 18) begin
        for (int i = 0; i < 300; i++) tick((i % 16) < 2, 1'b0);
      end else begin
        for (int i = 0; i < 37; i++) tick((i % 16) < 2, i < 4);
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0);
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
